// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared FSM state type and ALU control codes for alu_arbiter
//
// Purpose: shared definitions for the two-requester shared-ALU arbiter.
// Contents: state_e (IDLE/EXEC/RESP) and the 4-bit ALU control codes.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_ORR    = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_PASS_B = 4'b0111;

endpackage

// File: rtl/alu_rr_pick.sv
// rtl/alu_rr_pick.sv - two-way arbitration pick, round-robin or fixed priority
//
// Purpose: chooses one of two valid requesters and returns a one-hot grant.
// Config:  ALU_ARB_FIXED_PRIO_EN defined -> requester 0 always wins contention
//          and the last-grant pointer is ignored; undefined -> round-robin.
// Ports:
//   valid0_i, valid1_i : requester valid bits
//   last_i             : last-grant pointer (1 = requester 1 was granted last)
//   grant_o[1:0]       : one-hot grant, zero when no requester is valid
module alu_rr_pick (
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last_i;

    assign grant_o[0] = valid0_i;
    assign grant_o[1] = valid1_i & ~valid0_i;
`else
    // On contention the requester that was not granted last wins; a lone
    // valid requester wins whatever the pointer says.
    assign grant_o[0] = valid0_i & (~valid1_i | last_i);
    assign grant_o[1] = valid1_i & (~valid0_i | ~last_i);
`endif

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of a shared combinational ALU
//
// Purpose: accepts one operation at a time from two requesters, drives it to
//          an external ALU for one cycle, and returns the captured result.
// Config:  ALU_ARB_FIXED_PRIO_EN (see alu_rr_pick) selects fixed priority.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   reqN_valid/ready/op/a/b       : requester N operation handshake (N = 0,1)
//   alu_ctl, alu_a, alu_b         : drive to shared ALU, zero outside EXEC
//   alu_result, alu_zero          : combinational ALU outputs
//   resp_valid/ready/id/result/zero : response handshake and payload
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [3:0]       alu_ctl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero
);

    state_e           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;
    logic             last_q;
    logic             resp_valid_q;
    logic             resp_id_q;
    logic [WIDTH-1:0] resp_result_q;
    logic             resp_zero_q;

    logic [1:0]       grant;
    logic             in_idle;
    logic             in_exec;

    alu_rr_pick u_pick (
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .last_i   (last_q),
        .grant_o  (grant)
    );

    assign in_idle = (state_q == ST_IDLE);
    assign in_exec = (state_q == ST_EXEC);

    // Grant only qualifies ready while idle, so an accept is simply a
    // non-zero grant in IDLE and a withdrawn valid leaves no trace.
    assign req0_ready = in_idle & grant[0];
    assign req1_ready = in_idle & grant[1];

    assign alu_ctl = in_exec ? op_q : 4'b0000;
    assign alu_a   = in_exec ? a_q  : '0;
    assign alu_b   = in_exec ? b_q  : '0;

    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_zero   = resp_zero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= 4'b0000;
            a_q           <= '0;
            b_q           <= '0;
            id_q          <= 1'b0;
            last_q        <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        op_q    <= grant[1] ? req1_op : req0_op;
                        a_q     <= grant[1] ? req1_a  : req0_a;
                        b_q     <= grant[1] ? req1_b  : req0_b;
                        id_q    <= grant[1];
                        last_q  <= grant[1];
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_result_q <= alu_result;
                    resp_zero_q   <= alu_zero;
                    resp_id_q     <= id_q;
                    resp_valid_q  <= 1'b1;
                    state_q       <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
